// File: rtl/burst_buffer_pkg.sv
// Shared definitions for burst_buffer: state encoding and counter sizing.
package burst_buffer_pkg;

  localparam int unsigned STATE_W = 1;

  // Discarding pipeline-fill samples / packing burst samples
  localparam logic [STATE_W-1:0] S_SKIP = 1'b0;
  localparam logic [STATE_W-1:0] S_FILL = 1'b1;

  // Counter must reach max(initial_latency, m) without wrapping early
  function automatic int unsigned cnt_width(input int unsigned initial_latency,
                                            input int unsigned m);
    int unsigned mx;
    mx = (initial_latency > m) ? initial_latency : m;
    if (mx == 0) begin
      return 1;
    end
    return int'($clog2(mx + 1));
  endfunction

endpackage

// File: rtl/burst_buffer.sv
// Serial-to-parallel burst collector: drops INITIAL_LATENCY fill samples after
// reset/clear, then packs every M accepted samples into one parallel word and
// strobes out_valid for one cycle per completed burst.
// Optional build macro BURST_BUFFER_HOLD_EN: data_out comes from a separate
// bank that captures each completed burst and holds it until the next one.
module burst_buffer
  import burst_buffer_pkg::*;
#(
  parameter int unsigned INITIAL_LATENCY = 3,
  parameter int unsigned M               = 5,
  parameter int unsigned PRECISION       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 ce,
  input  logic [PRECISION-1:0] data_in,
  output logic [PRECISION-1:0] data_out [M-1:0],
  output logic                 out_valid
);

  localparam int unsigned CW = cnt_width(INITIAL_LATENCY, M);
  localparam int unsigned BW = M * PRECISION;

  // With no fill to discard, reset and clear land directly in FILL
  localparam logic [STATE_W-1:0] START_STATE = (INITIAL_LATENCY == 0) ? S_FILL : S_SKIP;
  localparam logic [CW-1:0]      SKIP_LAST   =
    CW'((INITIAL_LATENCY == 0) ? 32'd0 : INITIAL_LATENCY - 32'd1);
  localparam logic [CW-1:0]      FILL_LAST   = CW'(M - 32'd1);

  logic [STATE_W-1:0]          state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        valid_q, valid_d;
  // Packed shift register: slice 0 is the oldest sample, slice M-1 the newest
  logic [M-1:0][PRECISION-1:0] sreg_q, sreg_d;
  logic [M-1:0][PRECISION-1:0] bank_c;

  // Next-state, counter, shift and strobe logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    sreg_d  = sreg_q;
    if (clr) begin
      state_d = START_STATE;
      cnt_d   = '0;
    end else if (ce) begin
      case (state_q)
        S_SKIP: begin
          if (cnt_q == SKIP_LAST) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FILL: begin
          // Oldest sample falls off slice 0, data_in enters slice M-1
          sreg_d = BW'({data_in, sreg_q} >> PRECISION);
          if (cnt_q == FILL_LAST) begin
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = START_STATE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, strobe and shift register flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START_STATE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sreg_q  <= sreg_d;
    end
  end

`ifdef BURST_BUFFER_HOLD_EN
  logic [M-1:0][PRECISION-1:0] hold_q, hold_d;

  // Capture the burst that completes on this edge; clr leaves it untouched
  always_comb begin
    hold_d = hold_q;
    if (valid_d) begin
      hold_d = sreg_d;
    end
  end

  // Hold bank flops, cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign bank_c = hold_q;
`else
  assign bank_c = sreg_q;
`endif

  // Unpack the output bank onto the per-sample output array
  for (genvar g = 0; g < M; g++) begin : g_out
    assign data_out[g] = bank_c[g];
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_burst_buffer.sv
// Self-checking bench for burst_buffer (M=5, INITIAL_LATENCY=3, PRECISION=5):
// directed vector table followed by randomized traffic against a queue model.
module tb_burst_buffer;

  localparam int IL = 3;
  localparam int M  = 5;
  localparam int P  = 5;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         ce;
  logic [P-1:0] data_in;
  logic [P-1:0] dout [M-1:0];
  logic         out_valid;

  int n_cmp;
  int n_err;

  // Reference model: fill samples left to drop, partial burst, last burst
  int           m_skip;
  logic [P-1:0] m_q [$];
  logic         m_valid;
  logic [P-1:0] m_burst [M];
  logic [P-1:0] m_hold [M];

  typedef struct packed {
    logic                clr;
    logic                ce;
    logic [P-1:0]        din;
    logic                ev;
    logic                chk;
    logic [M-1:0][P-1:0] ed;
  } vec_t;

  vec_t tbl [$];

  burst_buffer #(
    .INITIAL_LATENCY(IL),
    .M(M),
    .PRECISION(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .ce(ce),
    .data_in(data_in),
    .data_out(dout),
    .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_skip  = IL;
    m_q.delete();
    m_valid = 1'b0;
    for (int i = 0; i < M; i++) begin
      m_burst[i] = '0;
      m_hold[i]  = '0;
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, settle 1 time unit
  task automatic drive(input logic c, input logic e, input logic [P-1:0] d);
    clr     = c;
    ce      = e;
    data_in = d;
    @(posedge clk);
    m_valid = 1'b0;
    if (c) begin
      m_skip = IL;
      m_q.delete();
    end else if (e) begin
      if (m_skip > 0) begin
        m_skip--;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == M) begin
          m_valid = 1'b1;
          for (int i = 0; i < M; i++) m_burst[i] = m_q[i];
          m_hold = m_burst;
          m_q.delete();
        end
      end
    end
    #1;
`ifdef BURST_BUFFER_HOLD_EN
    for (int i = 0; i < M; i++) chk5($sformatf("hold[%0d]", i), dout[i], m_hold[i]);
`endif
  endtask

  function automatic vec_t mk(input logic c, input logic e, input int d, input logic ev,
                              input logic chk, input int b0, input int b1, input int b2,
                              input int b3, input int b4);
    vec_t r;
    r.clr = c;
    r.ce  = e;
    r.din = P'(d);
    r.ev  = ev;
    r.chk = chk;
    r.ed  = {P'(b4), P'(b3), P'(b2), P'(b1), P'(b0)};
    return r;
  endfunction

  // Accepted sample, no strobe expected
  function automatic vec_t s(input int d);
    return mk(1'b0, 1'b1, d, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endfunction

  // Burst-completing sample with the expected burst, oldest first
  function automatic vec_t b(input int d, input int b0, input int b1, input int b2,
                             input int b3, input int b4);
    return mk(1'b0, 1'b1, d, 1'b1, 1'b1, b0, b1, b2, b3, b4);
  endfunction

  function automatic vec_t c1(input int d);
    return mk(1'b1, 1'b1, d, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t g(input int d);
    return mk(1'b0, 1'b0, d, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endfunction

  logic rc;
  logic re;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    clr     = 1'b1;
    ce      = 1'b1;
    data_in = '0;
    model_reset();

    // Reset holds outputs at zero
    #12;
    chk1("reset valid", out_valid, 1'b0);
    for (int i = 0; i < M; i++) chk5($sformatf("reset data[%0d]", i), dout[i], '0);
    rst_n = 1'b1;

    // clr held after reset release: outputs unchanged
    tbl.push_back(mk(1'b1, 1'b1, 7, 1'b0, 1'b1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b1, 9, 1'b0, 1'b1, 0, 0, 0, 0, 0));
    // Basic burst: 1,2,3 are fill
    tbl.push_back(s(1)); tbl.push_back(s(2)); tbl.push_back(s(3));
    tbl.push_back(s(10)); tbl.push_back(s(11)); tbl.push_back(s(12)); tbl.push_back(s(13));
    tbl.push_back(b(14, 10, 11, 12, 13, 14));
    // Back-to-back burst
    tbl.push_back(s(20)); tbl.push_back(s(21)); tbl.push_back(s(22)); tbl.push_back(s(23));
    tbl.push_back(b(24, 20, 21, 22, 23, 24));
    // Mid-burst clear drops the partial burst and restarts the fill discard
    tbl.push_back(s(30)); tbl.push_back(s(31)); tbl.push_back(c1(5));
    tbl.push_back(s(3)); tbl.push_back(s(10)); tbl.push_back(s(12));
    tbl.push_back(s(13)); tbl.push_back(s(22)); tbl.push_back(s(23)); tbl.push_back(s(24));
    tbl.push_back(b(20, 13, 22, 23, 24, 20));
    // ce gating inside a burst stretches it by the gated cycles
    tbl.push_back(s(1)); tbl.push_back(s(2));
    tbl.push_back(g(17)); tbl.push_back(g(18)); tbl.push_back(g(19));
    tbl.push_back(s(3)); tbl.push_back(s(4));
    tbl.push_back(b(5, 1, 2, 3, 4, 5));
    // clr on the burst-completing edge wins
    tbl.push_back(s(6)); tbl.push_back(s(7)); tbl.push_back(s(8)); tbl.push_back(s(9));
    tbl.push_back(c1(15));
    tbl.push_back(s(9)); tbl.push_back(s(9)); tbl.push_back(s(9));
    tbl.push_back(s(1)); tbl.push_back(s(2)); tbl.push_back(s(3)); tbl.push_back(s(4));
    tbl.push_back(b(31, 1, 2, 3, 4, 31));
    // ce low right after completion drops the strobe
    tbl.push_back(g(0));

    foreach (tbl[k]) begin
      drive(tbl[k].clr, tbl[k].ce, tbl[k].din);
      chk1($sformatf("vec%0d valid", k), out_valid, tbl[k].ev);
      if (tbl[k].chk) begin
        for (int i = 0; i < M; i++)
          chk5($sformatf("vec%0d data[%0d]", k, i), dout[i], tbl[k].ed[i]);
      end
    end

    // Randomized traffic against the model, with an async reset in the middle
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 300; n++) begin
        rc = ($urandom_range(0, 24) == 0);
        re = ($urandom_range(0, 3) != 0);
        drive(rc, re, P'($urandom));
        chk1("rand valid", out_valid, m_valid);
        if (m_valid) begin
          for (int i = 0; i < M; i++)
            chk5($sformatf("rand data[%0d]", i), dout[i], m_burst[i]);
        end
      end
      if (pass == 0) begin
        // Assert reset between edges: outputs must clear without a clock
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async reset valid", out_valid, 1'b0);
        for (int i = 0; i < M; i++)
          chk5($sformatf("async reset data[%0d]", i), dout[i], '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
